// File: rtl/mux21_arb_pkg.sv
// rtl/mux21_arb_pkg.sv - shared state encodings and defaults for the two-requester arbiter
package mux21_arb_pkg;

    localparam int MAX_HOLD_DEFAULT = 4;
    localparam int CNT_W            = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

    function automatic logic [1:0] gnt_of(input arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mux21.sv
// rtl/mux21.sv - single-bit 2:1 multiplexer
module mux21 (
    input  logic sel,
    input  logic i0,
    input  logic i1,
    output logic y
);

    assign y = sel ? i1 : i0;

endmodule

// File: rtl/mux21_arbiter.sv
// rtl/mux21_arbiter.sv - round-robin arbiter with bounded hold, steering one shared data bit
module mux21_arbiter
    import mux21_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       d0,
    input  logic       d1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       y
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_gnt_q, last_gnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             mux_y;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                case (req)
                    2'b01:   state_d = GRANT0;
                    2'b10:   state_d = GRANT1;
                    // last_gnt_q=1 means requester 1 was served last, so 0 wins
                    2'b11:   state_d = last_gnt_q ? GRANT0 : GRANT1;
                    default: state_d = IDLE;
                endcase
                if (state_d == GRANT0) last_gnt_d = 1'b0;
                if (state_d == GRANT1) last_gnt_d = 1'b1;
            end
            GRANT0: begin
                if (!req[0] || (req[1] && cnt_q == HOLD_LAST)) begin
                    state_d = IDLE;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT1: begin
                if (!req[1] || (req[0] && cnt_q == HOLD_LAST)) begin
                    state_d = IDLE;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = gnt_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
        end
    end

    mux21 u_mux (
        .sel (state_q == GRANT1),
        .i0  (d0),
        .i1  (d1),
        .y   (mux_y)
    );

    assign gnt  = gnt_q;
    assign busy = |gnt_q;
    assign y    = mux_y & busy;

endmodule

// File: tb/tb_mux21_arbiter.sv
// tb/tb_mux21_arbiter.sv - directed vector table, corner sequences and random sweep for mux21_arbiter
module tb_mux21_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       d0, d1;
    logic [1:0] gnt;
    logic       busy, y;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state for the random sweep
    logic [1:0] m_gnt;
    int         m_cnt;
    int         m_last;

    typedef struct packed {
        logic       rst;
        logic [1:0] req;
        logic       d0;
        logic       d1;
        logic [1:0] gnt;
        logic       y;
    } vec_t;

    vec_t vecs[16];

    mux21_arbiter #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .d0   (d0),
        .d1   (d1),
        .gnt  (gnt),
        .busy (busy),
        .y    (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [1:0] rq);
        int n;
        if (r) begin
            m_gnt = 2'b00; m_cnt = 0; m_last = 1;
        end else if (m_gnt == 2'b00) begin
            m_cnt = 0;
            if (rq == 2'b01 || (rq == 2'b11 && m_last == 1)) begin
                m_gnt = 2'b01; m_last = 0;
            end else if (rq == 2'b10 || rq == 2'b11) begin
                m_gnt = 2'b10; m_last = 1;
            end
        end else begin
            n = (m_gnt == 2'b10) ? 1 : 0;
            if (!rq[n] || (rq[1-n] && m_cnt == MH - 1)) m_gnt = 2'b00;
            else if (m_cnt < MH - 1) m_cnt++;
        end
    endtask

    task automatic cycle(input logic r, input logic [1:0] rq, input logic a, input logic b);
        @(negedge clk);
        rst = r; req = rq; d0 = a; d1 = b;
        @(posedge clk);
        model_step(r, rq);
        #1;
    endtask

    initial begin
        int pos;
        logic [1:0] exp_g;
        logic [1:0] prev_g;
        logic       other;
        int         run;
        logic       rr;
        logic [1:0] rq;
        logic       ra, rb;

        rst = 1'b1; req = 2'b00; d0 = 1'b0; d1 = 1'b0;
        m_gnt = 2'b00; m_cnt = 0; m_last = 1;

        //           rst   req    d0    d1    gnt    y
        vecs[0]  = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1};
        vecs[2]  = '{1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[6]  = '{1'b0, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0};
        vecs[7]  = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[8]  = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b10, 1'b1};
        vecs[9]  = '{1'b0, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b01, 1'b0};
        vecs[11] = '{1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[12] = '{1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1};
        vecs[13] = '{1'b1, 2'b11, 1'b1, 1'b1, 2'b00, 1'b0};
        vecs[14] = '{1'b0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1};
        vecs[15] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0};

        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].d0, vecs[i].d1);
            check($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            check($sformatf("vec%0d_busy", i), {1'b0, busy}, {1'b0, vecs[i].gnt != 2'b00});
            check($sformatf("vec%0d_y", i), {1'b0, y}, {1'b0, vecs[i].y});
        end

        // continuous contention: 4 cycles each with one idle cycle between
        cycle(1'b1, 2'b11, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 2'b11, 1'b1, 1'b1);
            pos = k % 10;
            exp_g = (pos < 4) ? 2'b01 : (pos == 4) ? 2'b00 : (pos < 9) ? 2'b10 : 2'b00;
            check($sformatf("rr_gnt_k%0d", k), gnt, exp_g);
        end

        // uncontended hold never drops
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            ra = 1'(k % 3 == 0);
            cycle(1'b0, 2'b01, ra, 1'b1);
            check($sformatf("hold_gnt_k%0d", k), gnt, 2'b01);
            check($sformatf("hold_y_k%0d", k), {1'b0, y}, {1'b0, ra});
        end

        // release from GRANT1 then hand over to requester 0
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 2'b10, 1'b0, 1'b1);
        cycle(1'b0, 2'b10, 1'b0, 1'b1);
        check("rel_pre", gnt, 2'b10);
        cycle(1'b0, 2'b01, 1'b1, 1'b1);
        check("rel_idle", gnt, 2'b00);
        cycle(1'b0, 2'b01, 1'b1, 1'b1);
        check("rel_next", gnt, 2'b01);

        // reset mid-grant at count 2, then requester 0 wins contention
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        cycle(1'b0, 2'b10, 1'b0, 1'b1);
        cycle(1'b0, 2'b10, 1'b0, 1'b1);
        cycle(1'b0, 2'b10, 1'b0, 1'b1);
        check("rstmid_pre", gnt, 2'b10);
        cycle(1'b1, 2'b11, 1'b1, 1'b1);
        check("rstmid_gnt", gnt, 2'b00);
        check("rstmid_y", {1'b0, y}, 2'b00);
        cycle(1'b0, 2'b11, 1'b1, 1'b1);
        check("rstmid_first", gnt, 2'b01);

        // random sweep against the reference model and invariants
        cycle(1'b1, 2'b00, 1'b0, 1'b0);
        prev_g = 2'b00;
        run    = 0;
        for (int k = 0; k < 10000; k++) begin
            rr = 1'($urandom_range(0, 199) == 0);
            rq = 2'($urandom_range(0, 3));
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            cycle(rr, rq, ra, rb);
            other = (gnt == 2'b01) ? rq[1] : rq[0];
            if (gnt != 2'b00 && gnt == prev_g && other) run++;
            else if (gnt != 2'b00 && other) run = 1;
            else run = 0;
            prev_g = gnt;
            check("rnd_gnt", gnt, m_gnt);
            check("rnd_not11", {1'b0, gnt == 2'b11}, 2'b00);
            check("rnd_y", {1'b0, y},
                  {1'b0, (m_gnt == 2'b01) ? ra : (m_gnt == 2'b10) ? rb : 1'b0});
            check("rnd_hold", {1'b0, run > MH}, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux21_arbiter.md
MUX21_ARBITER -- requirements
Module: mux21_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, 4, maximum consecutive grant cycles while the other requester waits (legal range 1..15).
REQ-002 The port list SHALL be: clk  input  1  single system clock, all logic on rising edge.
REQ-003 The port list SHALL include: rst  input  1  reset, synchronous and active-high.
REQ-004 The port list SHALL include: req  input  2  request, req[0] requester 0, req[1] requester 1.
REQ-005 The port list SHALL include: d0  input  1  data bit of requester 0.
REQ-006 The port list SHALL include: d1  input  1  data bit of requester 1.
REQ-007 The port list SHALL include: gnt  output  2  registered one-hot-or-zero grant.
REQ-008 The port list SHALL include: busy  output  1  high whenever gnt is non-zero.
REQ-009 The port list SHALL include: y  output  1  shared-resource output, the granted requester's data bit, else 0.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT0 and GRANT1; gnt SHALL be 2'b00, 2'b01 and 2'b10 respectively.
REQ-011 Grant latency SHALL be one cycle: a req sampled at edge N in IDLE yields gnt at edge N+1.
REQ-012 IDLE with only req[0] set SHALL go to GRANT0; with only req[1] set, to GRANT1; with req=00, it SHALL stay in IDLE.
REQ-013 IDLE with req=11 SHALL grant the requester not in last_gnt (round robin); last_gnt SHALL update on every entry into GRANT0/GRANT1.
REQ-014 A hold counter (4 bits) SHALL load 0 on grant entry, increment each granted cycle, and saturate at MAX_HOLD-1.
REQ-015 In GRANTn, a deasserted req[n] SHALL cause a move to IDLE on the next edge (release).
REQ-016 In GRANTn with req[n]=1, the other req=1 and counter==MAX_HOLD-1, the FSM SHALL move to IDLE (preemption).
REQ-017 In GRANTn with the other req=0, the grant SHALL persist indefinitely; the counter SHALL stay saturated.
REQ-018 Every grant change SHALL pass through exactly one IDLE cycle (break-before-make); gnt SHALL never be 2'b11.
REQ-019 y SHALL equal d0 in GRANT0, d1 in GRANT1 and 0 in IDLE; it SHALL be combinational from the registered state and the current d0/d1.
REQ-020 The mux select SHALL be (state==GRANT1), and y SHALL be gated with busy.
REQ-021 When release and preemption conditions hold in the same cycle, release SHALL apply; the outcome SHALL be IDLE either way.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, gnt=00, busy=0, counter=0 and last_gnt=1 so requester 0 wins the first contention.
REQ-023 Reset asserted mid-grant SHALL drop gnt to 00 on the following edge, with no partial or extra grant cycle.
REQ-024 req sampled during reset SHALL be ignored; arbitration SHALL begin at the first edge with rst=0.

Structure
REQ-025 State encodings and the MAX_HOLD default SHALL reside in shared package mux21_arb_pkg.
REQ-026 The output datapath SHALL be one instance of the existing 2:1 mux sub-module mux21 (sel, i0=d0, i1=d1, y); no other sub-modules SHALL be used.
REQ-027 All state (FSM, counter, last_gnt) SHALL be registered in clk; there SHALL be no latches and no combinational loops.

Verification
REQ-028 Scenario: reset, then req=01 at cycle 1 -> gnt=01 from cycle 2, y tracks d0, busy=1.
REQ-029 Scenario: MAX_HOLD=4, req=11 held -> gnt repeats 01 for 4 cycles, 00 for 1, 10 for 4, 00 for 1, with 01 first.
REQ-030 Scenario: GRANT1 with req[1] dropped at cycle k -> gnt=00 at k+1; with req[0]=1, gnt=01 at k+2.
REQ-031 Scenario: req=01 held for 20 cycles with req[1]=0 -> gnt stays 01 throughout, no IDLE gap.
REQ-032 Scenario: rst pulsed during GRANT1 at count 2 -> gnt=00 next edge; with req=11 after release, gnt=01 first.
REQ-033 Scenario: random req/d0/d1 for 10k cycles -> gnt never 11, y==0 whenever gnt==00, no grant held longer than MAX_HOLD cycles while the other requests.
